// File: rtl/core_pkg.sv
// Shared types for the memory arbiter: requester IDs and default bus widths.
package core_pkg;

  typedef enum logic {
    ARB_ID_DATA  = 1'b0,
    ARB_ID_INSTR = 1'b1
  } arb_id_e;

  localparam int unsigned MEM_DATA_WIDTH = 32;
  localparam int unsigned MEM_BE_WIDTH   = MEM_DATA_WIDTH / 8;

endpackage

// File: rtl/arb_id_fifo.sv
// In-order FIFO of requester IDs for granted transactions still awaiting a response.
module arb_id_fifo
  import core_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CntW  = $clog2(DEPTH + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  arb_id_e         push_id_i,
  input  logic            pop_i,
  output arb_id_e         head_o,
  output logic [CntW-1:0] count_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  arb_id_e         mem_q [DEPTH];
  logic [PtrW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CntW-1:0] count_q, count_d;

  // Explicit wrap keeps non-power-of-two depths correct.
  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q + CntW'(push_i) - CntW'(pop_i);
    if (pop_i) rd_d = (rd_q == PtrW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
    if (push_i) wr_d = (wr_q == PtrW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q] <= push_id_i;
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data requesters onto one memory port with in-order response routing.
// Define MEM_ARBITER_RR_EN for round-robin tie-breaking; default is fixed DATA-over-INSTR.
module mem_arbiter
  import core_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = MEM_DATA_WIDTH,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    instr_req_i,
  input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
  output logic                    instr_gnt_o,
  output logic                    instr_rvalid_o,
  output logic [DATA_WIDTH-1:0]   instr_rdata_o,
  input  logic                    data_req_i,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  output logic                    busy_o
);

  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);

  arb_id_e         winner, head_id, lock_owner_q, lock_owner_d;
  logic            lock_q, lock_d;
  logic            winner_req, eligible, mem_fire, pop;
  logic [CntW-1:0] cnt;

`ifdef MEM_ARBITER_RR_EN
  arb_id_e last_q;

  always_ff @(posedge clk) begin
    if (rst) last_q <= ARB_ID_DATA;
    else if (mem_fire) last_q <= winner;
  end
`endif

  always_comb begin
    winner = ARB_ID_DATA;
    if (lock_q) begin
      winner = lock_owner_q;
    end else if (data_req_i && instr_req_i) begin
`ifdef MEM_ARBITER_RR_EN
      winner = (last_q == ARB_ID_DATA) ? ARB_ID_INSTR : ARB_ID_DATA;
`else
      winner = ARB_ID_DATA;
`endif
    end else if (instr_req_i) begin
      winner = ARB_ID_INSTR;
    end
  end

  assign eligible   = cnt < CntW'(MAX_OUTSTANDING);
  assign winner_req = (winner == ARB_ID_DATA) ? data_req_i : instr_req_i;
  assign mem_req_o  = eligible & winner_req;
  assign mem_fire   = mem_req_o & mem_gnt_i;

  always_comb begin
    mem_we_o    = 1'b0;
    mem_be_o    = '1;
    mem_addr_o  = instr_addr_i;
    mem_wdata_o = '0;
    if (winner == ARB_ID_DATA) begin
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_addr_o  = data_addr_i;
      mem_wdata_o = data_wdata_i;
    end
  end

  assign data_gnt_o  = mem_fire & (winner == ARB_ID_DATA);
  assign instr_gnt_o = mem_fire & (winner == ARB_ID_INSTR);

  // A stalled request pins the owner until memory accepts it.
  assign lock_d       = mem_req_o & ~mem_gnt_i;
  assign lock_owner_d = lock_d ? winner : lock_owner_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q       <= 1'b0;
      lock_owner_q <= ARB_ID_DATA;
    end else begin
      lock_q       <= lock_d;
      lock_owner_q <= lock_owner_d;
    end
  end

  assign pop = mem_rvalid_i & (cnt != '0);

  arb_id_fifo #(
    .DEPTH(MAX_OUTSTANDING),
    .CntW (CntW)
  ) u_id_fifo (
    .clk_i    (clk),
    .rst_i    (rst),
    .push_i   (mem_fire),
    .push_id_i(winner),
    .pop_i    (pop),
    .head_o   (head_id),
    .count_o  (cnt)
  );

  assign data_rvalid_o  = pop & (head_id == ARB_ID_DATA);
  assign instr_rvalid_o = pop & (head_id == ARB_ID_INSTR);
  assign data_rdata_o   = mem_rdata_i;
  assign instr_rdata_o  = mem_rdata_i;
  assign busy_o         = cnt != '0;

  a_lock_held: assert property (@(posedge clk) disable iff (rst) lock_q |-> winner_req)
    else $error("requester dropped req while its request was locked");

  a_no_stray_rvalid: assert property (@(posedge clk) disable iff (rst) mem_rvalid_i |-> busy_o)
    else $warning("memory response with nothing outstanding was ignored");

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected response IDs queued at grant, checked at rvalid.
module tb_mem_arbiter;
  import core_pkg::*;

  logic        clk, rst;
  logic        instr_req_i, instr_gnt_o, instr_rvalid_o;
  logic [31:0] instr_addr_i, instr_rdata_o;
  logic        data_req_i, data_we_i, data_gnt_o, data_rvalid_o;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
  logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i, busy_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic        instr;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  mem_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .instr_req_i   (instr_req_i),
    .instr_addr_i  (instr_addr_i),
    .instr_gnt_o   (instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o),
    .instr_rdata_o (instr_rdata_o),
    .data_req_i    (data_req_i),
    .data_we_i     (data_we_i),
    .data_be_i     (data_be_i),
    .data_addr_i   (data_addr_i),
    .data_wdata_i  (data_wdata_i),
    .data_gnt_o    (data_gnt_o),
    .data_rvalid_o (data_rvalid_o),
    .data_rdata_o  (data_rdata_o),
    .mem_req_o     (mem_req_o),
    .mem_we_o      (mem_we_o),
    .mem_be_o      (mem_be_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rdata_i   (mem_rdata_i),
    .busy_o        (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    instr_req_i  = 1'b0;
    instr_addr_i = '0;
    data_req_i   = 1'b0;
    data_we_i    = 1'b0;
    data_be_i    = '0;
    data_addr_i  = '0;
    data_wdata_i = '0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic next_cyc();
    @(negedge clk);
    mem_rvalid_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic push_exp(input logic instr, input logic [31:0] d);
    exp_t e;
    e.instr = instr;
    e.data  = d;
    exp_q.push_back(e);
  endtask

  // Memory model: returns the oldest granted transaction's data.
  task automatic respond(output exp_t e);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
    end else begin
      e.instr = 1'bx;
      e.data  = 'x;
    end
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = e.data;
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if ({instr_gnt_o, data_gnt_o} !== 2'b00)
      $display("FAIL reset_gnt: got %b want 00", {instr_gnt_o, data_gnt_o});
    else n_pass++;
    n_checks++;
    if ({instr_rvalid_o, data_rvalid_o} !== 2'b00)
      $display("FAIL reset_rvalid: got %b want 00", {instr_rvalid_o, data_rvalid_o});
    else n_pass++;
    n_checks++;
    if ({mem_req_o, busy_o} !== 2'b00)
      $display("FAIL reset_req_busy: got %b want 00", {mem_req_o, busy_o});
    else n_pass++;
  endtask

  task automatic test_basic_fetch();
    exp_t e;
    next_cyc();
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h10;
    mem_gnt_i    = 1'b1;
    #1;
    n_checks++;
    if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h10})
      $display("FAIL fetch_addr: got req=%b addr=%h want req=1 addr=00000010", mem_req_o, mem_addr_o);
    else n_pass++;
    n_checks++;
    if ({instr_gnt_o, data_gnt_o, mem_we_o, mem_be_o} !== {1'b1, 1'b0, 1'b0, 4'hf})
      $display("FAIL fetch_gnt: got gnt=%b%b we=%b be=%h want 10 0 f",
               instr_gnt_o, data_gnt_o, mem_we_o, mem_be_o);
    else n_pass++;
    push_exp(1'b1, 32'hDEADBEEF);
    next_cyc();
    instr_req_i = 1'b0;
    mem_gnt_i   = 1'b0;
    #1;
    n_checks++;
    if (busy_o !== 1'b1) $display("FAIL fetch_busy: got %b want 1", busy_o);
    else n_pass++;
    next_cyc();
    respond(e);
    #1;
    n_checks++;
    if ({instr_rvalid_o, data_rvalid_o} !== {e.instr, ~e.instr} || instr_rdata_o !== 32'hDEADBEEF)
      $display("FAIL fetch_resp: got rv=%b%b rdata=%h want %b%b DEADBEEF",
               instr_rvalid_o, data_rvalid_o, instr_rdata_o, e.instr, ~e.instr);
    else n_pass++;
    next_cyc();
    #1;
    n_checks++;
    if (busy_o !== 1'b0) $display("FAIL fetch_idle: got busy=%b want 0", busy_o);
    else n_pass++;
  endtask

  task automatic test_conflict();
    exp_t e;
    logic first_instr;
`ifdef MEM_ARBITER_RR_EN
    first_instr = 1'b1;
`else
    first_instr = 1'b0;
`endif
    for (int i = 0; i < 2; i++) begin
      logic win_instr;
      win_instr = (i == 0) ? first_instr : ~first_instr;
      next_cyc();
      instr_req_i  = (i == 0) ? 1'b1 : ~first_instr;
      instr_addr_i = 32'h20;
      data_req_i   = (i == 0) ? 1'b1 : first_instr;
      data_addr_i  = 32'h100;
      data_we_i    = 1'b1;
      data_be_i    = 4'b0011;
      data_wdata_i = 32'hCAFE0000;
      mem_gnt_i    = 1'b1;
      #1;
      n_checks++;
      if ({instr_gnt_o, data_gnt_o} !== {win_instr, ~win_instr})
        $display("FAIL conflict_gnt%0d: got %b%b want %b%b", i, instr_gnt_o, data_gnt_o,
                 win_instr, ~win_instr);
      else n_pass++;
      n_checks++;
      if ({mem_addr_o, mem_we_o, mem_be_o} !==
          (win_instr ? {32'h20, 1'b0, 4'hf} : {32'h100, 1'b1, 4'b0011}))
        $display("FAIL conflict_bus%0d: got addr=%h we=%b be=%h", i, mem_addr_o, mem_we_o,
                 mem_be_o);
      else n_pass++;
      push_exp(win_instr, 32'h1111 * (i + 1));
    end
    next_cyc();
    idle();
    for (int i = 0; i < 2; i++) begin
      if (i != 0) next_cyc();
      respond(e);
      #1;
      n_checks++;
      if ({instr_rvalid_o, data_rvalid_o} !== {e.instr, ~e.instr} ||
          data_rdata_o !== e.data)
        $display("FAIL conflict_resp%0d: got rv=%b%b rdata=%h want %b%b %h", i,
                 instr_rvalid_o, data_rvalid_o, data_rdata_o, e.instr, ~e.instr, e.data);
      else n_pass++;
    end
  endtask

  task automatic test_lock();
    exp_t e;
    for (int c = 0; c < 5; c++) begin
      next_cyc();
      instr_req_i  = (c < 4);
      instr_addr_i = 32'h40;
      data_req_i   = (c >= 2);
      data_addr_i  = 32'h200;
      data_we_i    = 1'b0;
      data_be_i    = 4'hf;
      mem_gnt_i    = (c >= 3);
      #1;
      n_checks++;
      if ({mem_addr_o, instr_gnt_o, data_gnt_o} !==
          {(c < 4) ? 32'h40 : 32'h200, c == 3, c == 4})
        $display("FAIL lock_c%0d: got addr=%h gnt=%b%b want addr=%h gnt=%b%b", c, mem_addr_o,
                 instr_gnt_o, data_gnt_o, (c < 4) ? 32'h40 : 32'h200, c == 3, c == 4);
      else n_pass++;
      if (c == 3) push_exp(1'b1, 32'hA5A5A5A5);
      if (c == 4) push_exp(1'b0, 32'h5A5A5A5A);
    end
    next_cyc();
    idle();
    for (int i = 0; i < 2; i++) begin
      if (i != 0) next_cyc();
      respond(e);
      #1;
      n_checks++;
      if ({instr_rvalid_o, data_rvalid_o} !== {e.instr, ~e.instr} ||
          instr_rdata_o !== e.data)
        $display("FAIL lock_resp%0d: got rv=%b%b rdata=%h want %b%b %h", i, instr_rvalid_o,
                 data_rvalid_o, instr_rdata_o, e.instr, ~e.instr, e.data);
      else n_pass++;
    end
  endtask

  task automatic test_outstanding_limit();
    exp_t e;
    next_cyc();
    data_req_i  = 1'b1;
    data_addr_i = 32'h300;
    mem_gnt_i   = 1'b1;
    #1;
    n_checks++;
    if (data_gnt_o !== 1'b1) $display("FAIL limit_gnt0: got %b want 1", data_gnt_o);
    else n_pass++;
    push_exp(1'b0, 32'h33);
    next_cyc();
    data_req_i   = 1'b0;
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h50;
    #1;
    n_checks++;
    if (instr_gnt_o !== 1'b1) $display("FAIL limit_gnt1: got %b want 1", instr_gnt_o);
    else n_pass++;
    push_exp(1'b1, 32'h44);
    for (int c = 0; c < 2; c++) begin
      next_cyc();
      instr_req_i = 1'b0;
      data_req_i  = 1'b1;
      data_addr_i = 32'h304;
      #1;
      n_checks++;
      if ({mem_req_o, instr_gnt_o, data_gnt_o, busy_o} !== 4'b0001)
        $display("FAIL limit_full%0d: got req/gnt/busy=%b want 0001", c,
                 {mem_req_o, instr_gnt_o, data_gnt_o, busy_o});
      else n_pass++;
    end
    next_cyc();
    respond(e);
    #1;
    n_checks++;
    if ({instr_rvalid_o, data_rvalid_o, mem_req_o} !== {e.instr, ~e.instr, 1'b0} ||
        data_rdata_o !== e.data)
      $display("FAIL limit_resp0: got rv=%b%b req=%b rdata=%h want %b%b0 %h", instr_rvalid_o,
               data_rvalid_o, mem_req_o, data_rdata_o, e.instr, ~e.instr, e.data);
    else n_pass++;
    next_cyc();
    #1;
    n_checks++;
    if ({data_gnt_o, mem_addr_o} !== {1'b1, 32'h304})
      $display("FAIL limit_regrant: got gnt=%b addr=%h want 1 00000304", data_gnt_o, mem_addr_o);
    else n_pass++;
    push_exp(1'b0, 32'h55);
    next_cyc();
    idle();
    for (int i = 0; i < 2; i++) begin
      if (i != 0) next_cyc();
      respond(e);
      #1;
      n_checks++;
      if ({instr_rvalid_o, data_rvalid_o} !== {e.instr, ~e.instr} || data_rdata_o !== e.data)
        $display("FAIL limit_resp%0d: got rv=%b%b rdata=%h want %b%b %h", i + 1,
                 instr_rvalid_o, data_rvalid_o, data_rdata_o, e.instr, ~e.instr, e.data);
      else n_pass++;
    end
    next_cyc();
    #1;
    n_checks++;
    if (busy_o !== 1'b0) $display("FAIL limit_drained: got busy=%b want 0", busy_o);
    else n_pass++;
  endtask

  task automatic test_push_pop();
    exp_t e;
    next_cyc();
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h60;
    mem_gnt_i    = 1'b1;
    #1;
    n_checks++;
    if (instr_gnt_o !== 1'b1) $display("FAIL pushpop_gnt0: got %b want 1", instr_gnt_o);
    else n_pass++;
    push_exp(1'b1, 32'h66);
    next_cyc();
    instr_req_i  = 1'b0;
    data_req_i   = 1'b1;
    data_we_i    = 1'b1;
    data_addr_i  = 32'h400;
    respond(e);
    push_exp(1'b0, 32'h77);
    #1;
    n_checks++;
    if ({instr_rvalid_o, data_rvalid_o, data_gnt_o} !== {e.instr, ~e.instr, 1'b1})
      $display("FAIL pushpop_both: got rv=%b%b gnt=%b want %b%b1", instr_rvalid_o,
               data_rvalid_o, data_gnt_o, e.instr, ~e.instr);
    else n_pass++;
    next_cyc();
    idle();
    #1;
    n_checks++;
    if (busy_o !== 1'b1) $display("FAIL pushpop_count: got busy=%b want 1", busy_o);
    else n_pass++;
    next_cyc();
    respond(e);
    #1;
    n_checks++;
    if ({instr_rvalid_o, data_rvalid_o} !== {e.instr, ~e.instr} || data_rdata_o !== e.data)
      $display("FAIL pushpop_resp: got rv=%b%b rdata=%h want %b%b %h", instr_rvalid_o,
               data_rvalid_o, data_rdata_o, e.instr, ~e.instr, e.data);
    else n_pass++;
    next_cyc();
    #1;
    n_checks++;
    if (busy_o !== 1'b0) $display("FAIL pushpop_drained: got busy=%b want 0", busy_o);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    next_cyc();
    data_req_i  = 1'b1;
    data_addr_i = 32'h500;
    mem_gnt_i   = 1'b1;
    next_cyc();
    data_req_i   = 1'b0;
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h70;
    next_cyc();
    idle();
    #1;
    n_checks++;
    if (busy_o !== 1'b1) $display("FAIL rstmid_busy_before: got %b want 1", busy_o);
    else n_pass++;
    rst = 1'b1;
    next_cyc();
    rst = 1'b0;
    exp_q.delete();
    #1;
    n_checks++;
    if ({busy_o, mem_req_o} !== 2'b00)
      $display("FAIL rstmid_cleared: got busy/req=%b%b want 00", busy_o, mem_req_o);
    else n_pass++;
    next_cyc();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h0BAD0BAD;
    #1;
    n_checks++;
    if ({instr_rvalid_o, data_rvalid_o} !== 2'b00)
      $display("FAIL rstmid_stray: got rv=%b%b want 00", instr_rvalid_o, data_rvalid_o);
    else n_pass++;
    next_cyc();
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h80;
    mem_gnt_i    = 1'b1;
    #1;
    n_checks++;
    if ({instr_gnt_o, mem_addr_o} !== {1'b1, 32'h80})
      $display("FAIL rstmid_gnt: got gnt=%b addr=%h want 1 00000080", instr_gnt_o, mem_addr_o);
    else n_pass++;
    push_exp(1'b1, 32'h88);
    next_cyc();
    idle();
    respond(e);
    #1;
    n_checks++;
    if ({instr_rvalid_o, data_rvalid_o} !== {e.instr, ~e.instr} || instr_rdata_o !== e.data)
      $display("FAIL rstmid_resp: got rv=%b%b rdata=%h want %b%b %h", instr_rvalid_o,
               data_rvalid_o, instr_rdata_o, e.instr, ~e.instr, e.data);
    else n_pass++;
    next_cyc();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_basic_fetch();
    do_reset();
    test_conflict();
    test_lock();
    test_outstanding_limit();
    test_push_pop();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
